// File: rtl/shared_dff_bank_arbiter.sv
// shared_dff_bank_arbiter: round-robin write arbiter gating the enables of a shared DFF register bank
module shared_dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AW-1:0]     wr_addr,
    input  logic [NREQ*WIDTH-1:0]  wr_data,
    output logic [NREQ-1:0]        gnt,
    output logic [DEPTH*WIDTH-1:0] bank_q,
    output logic [DEPTH-1:0]       valid,
    output logic                   busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  pick;
    logic             found;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [DEPTH-1:0] en;

    // the requester acked this cycle sits out, so a stale req cannot win twice in a row
    assign elig    = req & ~gnt;
    assign ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign waddr   = wr_addr[win*AW +: AW];
    assign wdata   = wr_data[win*WIDTH +: WIDTH];

    // circular scan starting at ptr; first eligible requester wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && elig[idx]) begin
                found     = 1'b1;
                win       = idx;
                pick[idx] = 1'b1;
            end
        end
    end

    // per-register enables; out-of-range addresses decode to no register at all
    always_comb begin
        en = '0;
        for (int j = 0; j < DEPTH; j++)
            en[j] = found && (int'(waddr) == j);
    end

    // enable-gated register bank: only the decoded register loads the winner's data
    always_ff @(posedge clock) begin
        if (!reset) begin
            bank_q <= '0;
            valid  <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (en[j]) begin
                    bank_q[j*WIDTH +: WIDTH] <= wdata;
                    valid[j]                 <= 1'b1;
                end
            end
        end
    end

    // registered grant/ack, busy flag and round-robin pointer
    always_ff @(posedge clock) begin
        if (!reset) begin
            gnt  <= '0;
            busy <= 1'b0;
            ptr  <= '0;
        end else begin
            gnt  <= pick;
            busy <= found;
            if (found)
                ptr <= ptr_nxt;
        end
    end
endmodule

// File: tb/tb_shared_dff_bank_arbiter.sv
// tb_shared_dff_bank_arbiter: directed stimulus with a grant scoreboard for shared_dff_bank_arbiter
module tb_shared_dff_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int AW    = 2;

    logic                   clock   = 1'b0;
    logic                   reset   = 1'b0;
    logic [NREQ-1:0]        req     = '0;
    logic [NREQ*AW-1:0]     wr_addr = '0;
    logic [NREQ*WIDTH-1:0]  wr_data = '0;
    logic [NREQ-1:0]        gnt;
    logic [DEPTH*WIDTH-1:0] bank_q;
    logic [DEPTH-1:0]       valid;
    logic                   busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string                  tag;
        logic [NREQ-1:0]        g;
        logic [DEPTH*WIDTH-1:0] b;
        logic [DEPTH-1:0]       v;
    } exp_t;

    exp_t q[$];

    logic [DEPTH*WIDTH-1:0] mbank  = '0;
    logic [DEPTH-1:0]       mvalid = '0;

    shared_dff_bank_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .gnt    (gnt),
        .bank_q (bank_q),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_addr[i*AW +: AW]       = a;
        wr_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic model_clear;
        mbank  = '0;
        mvalid = '0;
    endtask

    task automatic expect_wr(input string tag, input logic [NREQ-1:0] g, input int a, input logic [WIDTH-1:0] d);
        exp_t e;
        if (a < DEPTH) begin
            mbank[a*WIDTH +: WIDTH] = d;
            mvalid[a]               = 1'b1;
        end
        e.tag = tag;
        e.g   = g;
        e.b   = mbank;
        e.v   = mvalid;
        q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0 || bank_q !== mbank || valid !== mvalid) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b busy=%b bank_q=%h valid=%b, want gnt=0000 busy=0 bank_q=%h valid=%b",
                     tag, gnt, busy, bank_q, valid, mbank, mvalid);
        end
    endtask

    // monitor: every presented grant pops the next expected write
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (busy || gnt != '0) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_grant: got gnt=%b busy=%b, want no grant", gnt, busy);
                end else begin
                    e = q.pop_front();
                    if (gnt !== e.g || busy !== 1'b1 || bank_q !== e.b || valid !== e.v) begin
                        n_bad++;
                        $display("FAIL %s: got gnt=%b busy=%b bank_q=%h valid=%b, want gnt=%b busy=1 bank_q=%h valid=%b",
                                 e.tag, gnt, busy, bank_q, valid, e.g, e.b, e.v);
                    end
                end
            end
        end
    end

    initial begin
        tick;
        reset = 1'b0;
        req   = 4'b1111;
        set_wr(0, 2'd0, 8'h10);
        set_wr(1, 2'd1, 8'h21);
        set_wr(2, 2'd2, 8'h32);
        set_wr(3, 2'd3, 8'h43);
        tick; check_idle("reset_c1");
        tick; check_idle("reset_c2");
        reset = 1'b1;
        expect_wr("rr_g0", 4'b0001, 0, 8'h10);
        tick; set_wr(0, 2'd0, 8'h50);
        expect_wr("rr_g1", 4'b0010, 1, 8'h21);
        tick; expect_wr("rr_g2", 4'b0100, 2, 8'h32);
        tick; expect_wr("rr_g3_oor", 4'b1000, 3, 8'h43);
        tick; expect_wr("rr_g0_wrap", 4'b0001, 0, 8'h50);
        tick; req = 4'b0000;
        tick; check_idle("rr_drop");
        req = 4'b1111;
        expect_wr("mid_g1", 4'b0010, 1, 8'h21);
        tick; reset = 1'b0; model_clear;
        tick; check_idle("mid_reset");
        reset = 1'b1;
        req   = 4'b1110;
        expect_wr("mid_post_ptr0", 4'b0010, 1, 8'h21);
        tick; req = 4'b0000;
        tick; check_idle("mid_drop");
        req = 4'b0010;
        set_wr(1, 2'd2, 8'hA5);
        expect_wr("single", 4'b0010, 2, 8'hA5);
        tick; req = 4'b0000;
        tick; check_idle("single_drop");
        reset = 1'b0; model_clear;
        tick; check_idle("reset2");
        reset = 1'b1;
        req   = 4'b0101;
        set_wr(0, 2'd1, 8'h11);
        set_wr(2, 2'd1, 8'h22);
        expect_wr("conf_r0", 4'b0001, 1, 8'h11);
        tick; req = 4'b0100;
        expect_wr("conf_r2", 4'b0100, 1, 8'h22);
        tick; req = 4'b0000;
        tick; check_idle("conf_drop");
        req = 4'b1000;
        set_wr(3, 2'd3, 8'hEE);
        expect_wr("oor", 4'b1000, 3, 8'hEE);
        tick; req = 4'b0000;
        tick; check_idle("oor_drop");
        req = 4'b1001;
        set_wr(0, 2'd0, 8'h77);
        expect_wr("wrap_r0", 4'b0001, 0, 8'h77);
        tick; req = 4'b1000;
        expect_wr("wrap_r3", 4'b1000, 3, 8'hEE);
        tick; req = 4'b0000;
        tick; check_idle("wrap_drop");
        req = 4'b0001;
        set_wr(0, 2'd2, 8'h3C);
        expect_wr("mask_a", 4'b0001, 2, 8'h3C);
        tick;
        tick; check_idle("mask_gap");
        set_wr(0, 2'd2, 8'hC3);
        expect_wr("mask_b", 4'b0001, 2, 8'hC3);
        tick; req = 4'b0000;
        tick; check_idle("end");
        tick;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending: got %0d grants outstanding, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
